// File: rtl/mcs4_port_monitor.sv
// Board-side monitor for the MCS-4 output pins: synchronizes p_out/io_pad into sysclk,
// timestamps every change of the 18-bit pin vector and queues it in a show-ahead FIFO.
module mcs4_port_monitor #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TS_W  = 12
) (
    input  logic              sysclk,
    input  logic              poc_pad,
    input  logic              clear_pad,
    input  logic [9:0]        p_out,
    input  logic [7:0]        io_pad,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [TS_W+17:0]  evt_data,
    output logic              overflow
);

    localparam int unsigned PIN_W = 18;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned EW    = TS_W + PIN_W;

    logic [PIN_W-1:0] s1_q, s2_q, h_q;
    logic [TS_W-1:0]  ts_q, ts_d;
    logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic             ovf_q, ovf_d;
    logic [EW-1:0]    mem_q [DEPTH];

    logic chg, empty, full, pop, push;

    // Change detect, FIFO status and handshake decode
    always_comb begin
        chg   = (s2_q != h_q);
        empty = (wptr_q == rptr_q);
        full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        pop   = !empty && evt_ready;
        push  = chg && (!full || pop);
    end

    // Next state; clear flushes the queue and drops any event detected this cycle
    always_comb begin
        ts_d   = ts_q + TS_W'(1);
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        ovf_d  = ovf_q;
        if (clear_pad) begin
            ts_d   = '0;
            wptr_d = '0;
            rptr_d = '0;
            ovf_d  = 1'b0;
        end else begin
            if (push) wptr_d = wptr_q + (AW+1)'(1);
            if (pop)  rptr_d = rptr_q + (AW+1)'(1);
            if (chg && full && !pop) ovf_d = 1'b1;
        end
    end

    // Synchronizer, history, timestamp, pointers and sticky overflow
    always_ff @(posedge sysclk) begin
        if (poc_pad) begin
            s1_q   <= '0;
            s2_q   <= '0;
            h_q    <= '0;
            ts_q   <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            s1_q   <= {p_out, io_pad};
            s2_q   <= s1_q;
            h_q    <= s2_q;
            ts_q   <= ts_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            ovf_q  <= ovf_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the queue is empty
    always_ff @(posedge sysclk) begin
        if (!poc_pad && !clear_pad && push) begin
            mem_q[wptr_q[AW-1:0]] <= {ts_q, s2_q};
        end
    end

    assign evt_valid = !empty;
    assign evt_data  = empty ? '0 : mem_q[rptr_q[AW-1:0]];
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_mcs4_port_monitor.sv
// Self-checking bench for mcs4_port_monitor: scoreboard of expected events, one task per scenario.
module tb_mcs4_port_monitor;

    logic        sysclk = 1'b0;
    logic        poc_pad;
    logic        clear_pad;
    logic [9:0]  p_out;
    logic [7:0]  io_pad;
    logic        evt_valid;
    logic        evt_ready;
    logic [29:0] evt_data;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    logic [11:0] tb_ts = '0;
    logic [29:0] sb [$];

    mcs4_port_monitor #(.DEPTH(4), .TS_W(12)) dut (
        .sysclk    (sysclk),
        .poc_pad   (poc_pad),
        .clear_pad (clear_pad),
        .p_out     (p_out),
        .io_pad    (io_pad),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_data  (evt_data),
        .overflow  (overflow)
    );

    always #5 sysclk = ~sysclk;

    // Reference timestamp: zero at any edge with reset or clear sampled, else +1
    always @(posedge sysclk) begin
        if (poc_pad || clear_pad) tb_ts <= '0;
        else                      tb_ts <= tb_ts + 12'd1;
    end

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    // Drive new pins just after an edge; a retained event carries ts of two edges later
    task automatic set_pins(input logic [9:0] p, input logic [7:0] io, input bit keep);
        p_out  = p;
        io_pad = io;
        if (keep) sb.push_back({12'(tb_ts + 12'd2), p, io});
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Wait (bounded) for a head entry, compare it to the scoreboard, then pop it
    task automatic pop_check(input string name);
        logic [29:0] exp;
        int guard;
        guard = 0;
        while (!evt_valid && guard < 10) begin
            tick();
            guard++;
        end
        total++;
        if (!evt_valid) begin
            bad++;
            $display("FAIL %s: evt_valid never rose (timeout)", name);
        end else if (sb.size() == 0) begin
            bad++;
            $display("FAIL %s: unexpected event got %h expected none", name, evt_data);
            evt_ready = 1'b1;
            tick();
            evt_ready = 1'b0;
        end else begin
            exp = sb.pop_front();
            if (evt_data !== exp) begin
                bad++;
                $display("FAIL %s: evt_data got %h expected %h", name, evt_data, exp);
            end
            evt_ready = 1'b1;
            tick();
            evt_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        poc_pad   = 1'b1;
        clear_pad = 1'b0;
        evt_ready = 1'b0;
        set_pins(10'h000, 8'h00, 1'b0);
        repeat (3) tick();
        check_bit("reset_valid", evt_valid, 1'b0);
        total++;
        if (evt_data !== 30'h0) begin
            bad++;
            $display("FAIL reset_data: got %h expected 0", evt_data);
        end
        check_bit("reset_overflow", overflow, 1'b0);
        poc_pad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_bit("idle_no_event", evt_valid, 1'b0);
        end
    endtask

    task automatic test_single();
        set_pins(10'h001, io_pad, 1'b1);
        tick();
        tick();
        check_bit("single_not_early", evt_valid, 1'b0);
        tick();
        check_bit("single_valid", evt_valid, 1'b1);
        pop_check("single_data");
        check_bit("single_after_pop", evt_valid, 1'b0);
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 5; i++) begin
            set_pins(p_out, 8'(i), i <= 4);
            repeat (3) tick();
            if (i == 4) check_bit("ovf_before_drop", overflow, 1'b0);
        end
        check_bit("ovf_set", overflow, 1'b1);
        for (int i = 0; i < 4; i++) pop_check("ovf_drain");
        check_bit("ovf_drained_empty", evt_valid, 1'b0);
        check_bit("ovf_sticky", overflow, 1'b1);
    endtask

    task automatic test_flush();
        for (int i = 6; i <= 8; i++) begin
            set_pins(p_out, 8'(i), 1'b1);
            repeat (3) tick();
        end
        check_bit("flush_pre_valid", evt_valid, 1'b1);
        check_bit("flush_pre_ovf", overflow, 1'b1);
        set_pins(p_out, 8'h09, 1'b0);
        tick();
        tick();
        clear_pad = 1'b1;
        tick();
        clear_pad = 1'b0;
        sb.delete();
        check_bit("flush_valid", evt_valid, 1'b0);
        check_bit("flush_ovf", overflow, 1'b0);
        repeat (4) tick();
        check_bit("flush_event_absent", evt_valid, 1'b0);
        set_pins(p_out, 8'h0A, 1'b1);
        pop_check("flush_ts_restart");
    endtask

    task automatic test_full_push_pop();
        logic [29:0] exp;
        for (int i = 16; i <= 19; i++) begin
            set_pins(p_out, 8'(i), 1'b1);
            repeat (3) tick();
        end
        check_bit("fpp_full_valid", evt_valid, 1'b1);
        check_bit("fpp_full_ovf", overflow, 1'b0);
        set_pins(p_out, 8'h14, 1'b1);
        tick();
        tick();
        exp = sb.pop_front();
        total++;
        if (evt_data !== exp) begin
            bad++;
            $display("FAIL fpp_head: evt_data got %h expected %h", evt_data, exp);
        end
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        check_bit("fpp_ovf", overflow, 1'b0);
        for (int i = 0; i < 4; i++) pop_check("fpp_drain");
        check_bit("fpp_empty", evt_valid, 1'b0);
    endtask

    task automatic test_back_to_back_wrap();
        logic [29:0] exp;
        int guard, got, last_i;
        guard  = 0;
        got    = 0;
        last_i = -1;
        evt_ready = 1'b1;
        while (tb_ts != 12'd4092 && guard < 6000) begin
            tick();
            guard++;
        end
        total++;
        if (tb_ts != 12'd4092) begin
            bad++;
            $display("FAIL wrap_wait: timestamp window not reached (timeout)");
        end
        for (int i = 0; i < 10; i++) begin
            if (i < 4) set_pins(p_out ^ 10'h200, io_pad, 1'b1);
            tick();
            if (evt_valid) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL wrap_extra: got %h expected none", evt_data);
                end else begin
                    exp = sb.pop_front();
                    if (evt_data !== exp || (last_i >= 0 && i != last_i + 1)) begin
                        bad++;
                        $display("FAIL wrap_event: got %h expected %h (cycle %0d after %0d)",
                                 evt_data, exp, i, last_i);
                    end
                end
                got++;
                last_i = i;
            end
        end
        evt_ready = 1'b0;
        total++;
        if (got != 4 || sb.size() != 0) begin
            bad++;
            $display("FAIL wrap_count: got %0d events expected 4 (left %0d)", got, sb.size());
        end
    endtask

    task automatic test_reset_pins();
        poc_pad = 1'b1;
        set_pins(10'h155, 8'hAA, 1'b0);
        sb.delete();
        tick();
        tick();
        poc_pad = 1'b0;
        sb.push_back({12'(tb_ts + 12'd2), 10'h155, 8'hAA});
        check_bit("rstpins_idle", evt_valid, 1'b0);
        pop_check("rstpins_event");
        repeat (3) tick();
        check_bit("rstpins_single", evt_valid, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_flush();
        test_full_push_pop();
        test_back_to_back_wrap();
        test_reset_pins();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
